// File: rtl/rv32x_pkg.sv
// Shared constants and types for the RV32I_X core and its closely-coupled memories.
package rv32x_pkg;
  localparam int unsigned RV_ICCM_DEPTH = 16384;
  localparam int unsigned RV_DCCM_DEPTH = 16384;
  localparam logic [31:0] RV_ICCM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RV_DCCM_BASE  = 32'h0001_0000;
  localparam logic [31:0] RV_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } lsu_req_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_ICCM, SEL_DCCM} lsu_sel_e;
endpackage

// File: rtl/rv32_x_core.sv
// Minimal multi-cycle RV32I subset core (LUI, ADDI, JAL, loads, stores).
module rv32_x_core import rv32x_pkg::*; #(
  parameter logic [31:0] RESET_PC = RV_ICCM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic [31:0] ifu_rdata,
  output logic        lsu_req,
  output lsu_req_t    lsu,
  input  logic [31:0] lsu_rdata,
  input  logic        lsu_rvalid
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_IMM = 7'h13, OP_JAL = 7'h6f;
  localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rf [0:31];
  logic [31:0] ins, rs1, rs2, imm_i, imm_s, imm_j, addr, ld, rd_val;
  logic        rd_we;

  // The fetched word stays in the ICCM output register until the next fetch,
  // so decode fields remain valid through the load wait state.
  assign ins      = ifu_rdata;
  assign rs1      = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
  assign rs2      = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
  assign imm_i    = {{20{ins[31]}}, ins[31:20]};
  assign imm_s    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_j    = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign addr     = rs1 + ((ins[6:0] == OP_STORE) ? imm_s : imm_i);
  assign ld       = lsu_rdata >> {addr[1:0], 3'b000};
  assign ifu_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu     = '0;
    rd_we   = 1'b0;
    rd_val  = '0;
    case (state_q)
      S_FETCH: begin
        ifu_req = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 32'd4;
        case (ins[6:0])
          OP_LUI: begin rd_we = 1'b1; rd_val = {ins[31:12], 12'd0}; end
          OP_IMM: begin rd_we = 1'b1; rd_val = rs1 + imm_i; end
          OP_JAL: begin rd_we = 1'b1; rd_val = pc_q + 32'd4; pc_d = pc_q + imm_j; end
          OP_LOAD: begin
            lsu_req  = 1'b1;
            lsu.addr = addr;
            pc_d     = pc_q;
            state_d  = S_MEM;
          end
          OP_STORE: begin
            lsu_req  = 1'b1;
            lsu.we   = 1'b1;
            lsu.addr = addr;
            case (ins[13:12])
              2'b00:   begin lsu.wstrb = 4'b0001 << addr[1:0]; lsu.wdata = {4{rs2[7:0]}}; end
              2'b01:   begin lsu.wstrb = 4'b0011 << addr[1:0]; lsu.wdata = {2{rs2[15:0]}}; end
              default: begin lsu.wstrb = 4'b1111; lsu.wdata = rs2; end
            endcase
          end
          default: ;
        endcase
      end
      S_MEM: if (lsu_rvalid) begin
        rd_we   = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
        case (ins[14:12])
          3'b000:  rd_val = {{24{ld[7]}}, ld[7:0]};
          3'b001:  rd_val = {{16{ld[15]}}, ld[15:0]};
          3'b100:  rd_val = {24'd0, ld[7:0]};
          3'b101:  rd_val = {16'd0, ld[15:0]};
          default: rd_val = ld;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end

  always_ff @(posedge clk)
    if (rd_we && ins[11:7] != 5'd0) rf[ins[11:7]] <= rd_val;
endmodule

// File: rtl/rv32x_mem.sv
// ICCM/DCCM subsystem: address decode, LSU read mux and read-valid pipe.
module rv32x_mem import rv32x_pkg::*; #(
  parameter int unsigned ICCM_DEPTH = RV_ICCM_DEPTH,
  parameter int unsigned DCCM_DEPTH = RV_DCCM_DEPTH,
  parameter logic [31:0] ICCM_BASE  = RV_ICCM_BASE,
  parameter logic [31:0] DCCM_BASE  = RV_DCCM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  lsu_req_t    lsu,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rvalid
);
  localparam int unsigned IAW = $clog2(ICCM_DEPTH);
  localparam int unsigned DAW = $clog2(DCCM_DEPTH);

  logic [31:0] ifu_off, lsu_ioff, lsu_doff;
  logic        ifu_hit, lsu_ihit, lsu_dhit, lsu_rd;
  logic [1:0][31:0] iccm_rd;
  logic [0:0][31:0] dccm_rd;
  logic        ifu_hit_q;
  lsu_sel_e    sel_q;

  assign ifu_off  = ifu_addr - ICCM_BASE;
  assign lsu_ioff = lsu.addr - ICCM_BASE;
  assign lsu_doff = lsu.addr - DCCM_BASE;
  assign ifu_hit  = ifu_off  < 32'(4*ICCM_DEPTH);
  assign lsu_ihit = lsu_ioff < 32'(4*ICCM_DEPTH);
  assign lsu_dhit = lsu_doff < 32'(4*DCCM_DEPTH);
  assign lsu_rd   = lsu_req & ~lsu.we;

  // ICCM: write port disabled; read port 1 serves fetch, port 0 serves LSU loads.
  if (1'b1) begin : iccm
    rv32x_sram #(.DEPTH(ICCM_DEPTH), .NRD(2)) iccm_i0 (
      .clk(clk), .rst_n(rst_n),
      .we(1'b0), .waddr('0), .wstrb('0), .wdata('0),
      .ren({ifu_req & ifu_hit, lsu_rd & lsu_ihit}),
      .raddr({ifu_off[IAW+1:2], lsu_ioff[IAW+1:2]}),
      .rdata(iccm_rd)
    );
  end

  if (1'b1) begin : dccm
    rv32x_sram #(.DEPTH(DCCM_DEPTH), .NRD(1)) dccm_d0 (
      .clk(clk), .rst_n(rst_n),
      .we(lsu_req & lsu.we & lsu_dhit), .waddr(lsu_doff[DAW+1:2]),
      .wstrb(lsu.wstrb), .wdata(lsu.wdata),
      .ren(lsu_rd & lsu_dhit), .raddr(lsu_doff[DAW+1:2]),
      .rdata(dccm_rd)
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ifu_hit_q  <= 1'b0;
      sel_q      <= SEL_NONE;
      lsu_rvalid <= 1'b0;
    end else begin
      lsu_rvalid <= lsu_rd;
      if (ifu_req) ifu_hit_q <= ifu_hit;
      if (lsu_rd)  sel_q <= lsu_dhit ? SEL_DCCM : (lsu_ihit ? SEL_ICCM : SEL_NONE);
    end

  assign ifu_rdata = ifu_hit_q ? iccm_rd[1] : RV_NOP;

  always_comb begin
    lsu_rdata = '0;
    case (sel_q)
      SEL_ICCM: lsu_rdata = iccm_rd[0];
      SEL_DCCM: lsu_rdata = dccm_rd[0];
      default:  ;
    endcase
  end
endmodule

// File: rtl/rv32x_sram.sv
// Word RAM with one byte-masked write port and NRD synchronous read ports.
module rv32x_sram #(
  parameter  int unsigned DEPTH = 1024,
  parameter  int unsigned NRD   = 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              wdata,
  input  logic [NRD-1:0]           ren,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][31:0]     rdata
);
  // Array is never reset so backdoor-loaded images survive rst_n.
  logic [31:0] ram_core [0:DEPTH-1];

  always_ff @(posedge clk)
    if (we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ram_core[waddr][8*b +: 8] <= wdata[8*b +: 8];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else
      for (int p = 0; p < NRD; p++)
        if (ren[p]) rdata[p] <= ram_core[raddr[p]];
endmodule

// File: rtl/rv32x_wrapper.sv
// RV32I_X top: core plus ICCM/DCCM; runs autonomously from backdoor-loaded images.
module rv32x_wrapper #(
  parameter int unsigned ICCM_DEPTH = rv32x_pkg::RV_ICCM_DEPTH,
  parameter int unsigned DCCM_DEPTH = rv32x_pkg::RV_DCCM_DEPTH,
  parameter logic [31:0] ICCM_BASE  = rv32x_pkg::RV_ICCM_BASE,
  parameter logic [31:0] DCCM_BASE  = rv32x_pkg::RV_DCCM_BASE
) (
  input logic clk,
  input logic rst_n
);
  logic                ifu_req;
  logic [31:0]         ifu_addr, ifu_rdata;
  logic                lsu_req, lsu_rvalid;
  rv32x_pkg::lsu_req_t lsu;
  logic [31:0]         lsu_rdata;

  rv32_x_core #(.RESET_PC(ICCM_BASE)) core_i (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu(lsu), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid)
  );

  rv32x_mem #(
    .ICCM_DEPTH(ICCM_DEPTH), .DCCM_DEPTH(DCCM_DEPTH),
    .ICCM_BASE(ICCM_BASE), .DCCM_BASE(DCCM_BASE)
  ) mem_i (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu(lsu), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid)
  );
endmodule

// File: tb/tb_rv32x_wrapper.sv
// Directed-random programs on rv32x_wrapper, checked against ISA-level expectations.
module tb_rv32x_wrapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int rv_cnt = 0;
  logic [31:0] prog [$];

  rv32x_wrapper dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && dut.lsu_rvalid) rv_cnt++;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'h37};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'd2, rd, 7'h03);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset, load the current program, then release on a falling edge.
  task automatic start_prog();
    rst_n = 1'b0;
    foreach (prog[i]) dut.mem_i.iccm.iccm_i0.ram_core[i] = prog[i];
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_dccm(input string tag, input int idx, input logic [31:0] exp, input int limit);
    int n = 0;
    while (dut.mem_i.dccm.dccm_d0.ram_core[idx] !== exp && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, dut.mem_i.dccm.dccm_d0.ram_core[idx], exp);
  endtask

  task automatic wait_rvalid(input string tag, input int limit);
    int n = 0;
    while (dut.lsu_rvalid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(dut.lsu_rvalid), 32'd1);
  endtask

  initial begin
    int sv, rv0, lane;
    logic [31:0] v, d, w, d0, exp, c1, c2;
    logic [7:0] b;
    logic [7:0] by [4];

    // Reset state
    #1;
    chk("rst_ifu_rdata", dut.ifu_rdata, 32'h0000_0013);
    chk("rst_lsu_rdata", dut.lsu_rdata, 32'h0);
    chk("rst_lsu_rvalid", 32'(dut.lsu_rvalid), 32'd0);
    chk("rst_pc", dut.ifu_addr, 32'h0);

    // addi + sw to DCCM base, random signed immediate
    sv = int'($urandom_range(0, 4095)) - 2048;
    v = 32'(sv);
    dut.mem_i.dccm.dccm_d0.ram_core[0] = ~v;
    prog = '{addi(5'd1, 5'd0, v), enc_lui(20'h10, 5'd2), enc_s(32'd0, 5'd1, 5'd2, 3'd2), enc_jal(32'd0, 5'd0)};
    start_prog();
    #1;
    chk("first_fetch", {dut.ifu_req, dut.ifu_addr}, 33'h1_0000_0000);
    rv0 = rv_cnt;
    wait_dccm("sw_basic", 0, v, 20);
    repeat (10) @(negedge clk);
    chk("sw_no_rvalid", 32'(rv_cnt - rv0), 32'd0);

    // lw from backdoor word 1, sw to word 2
    d = $urandom();
    dut.mem_i.dccm.dccm_d0.ram_core[1] = d;
    dut.mem_i.dccm.dccm_d0.ram_core[2] = ~d;
    prog = '{enc_lui(20'h10, 5'd2), lw(5'd3, 5'd2, 32'd4), enc_s(32'd8, 5'd3, 5'd2, 3'd2), enc_jal(32'd0, 5'd0)};
    start_prog();
    rv0 = rv_cnt;
    wait_dccm("lw_sw_copy", 2, d, 30);
    repeat (10) @(negedge clk);
    chk("lw_one_rvalid", 32'(rv_cnt - rv0), 32'd1);

    // sb into one byte lane; first case is the fixed 0xAA-over-0x11223344 example
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin w = 32'h1122_3344; b = 8'hAA; lane = 3; end
      else begin w = $urandom(); b = 8'($urandom()); lane = int'($urandom_range(0, 3)); end
      for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
      by[lane] = b;
      exp = {by[3], by[2], by[1], by[0]};
      dut.mem_i.dccm.dccm_d0.ram_core[0] = w;
      prog = '{enc_lui(20'h10, 5'd2), addi(5'd1, 5'd0, {24'd0, b}),
               enc_s(32'(lane), 5'd1, 5'd2, 3'd0), enc_jal(32'd0, 5'd0)};
      start_prog();
      wait_dccm($sformatf("sb_lane%0d", lane), 0, exp, 30);
      repeat (5) @(negedge clk);
      chk("sb_stable", dut.mem_i.dccm.dccm_d0.ram_core[0], exp);
    end

    // Store then loop on a load; reset while a read response is on the bus
    v = $urandom() | 32'h1;
    v = {21'd0, v[10:0]};
    dut.mem_i.dccm.dccm_d0.ram_core[3] = ~v;
    prog = '{enc_lui(20'h10, 5'd2), addi(5'd1, 5'd0, v), enc_s(32'd12, 5'd1, 5'd2, 3'd2),
             lw(5'd3, 5'd2, 32'd12), enc_jal(-32'sd4, 5'd0)};
    start_prog();
    wait_rvalid("mid_rvalid_seen", 40);
    chk("raw_rdata", dut.lsu_rdata, v);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(dut.lsu_rvalid), 32'd0);
    chk("mid_rst_pc", dut.ifu_addr, 32'h0);
    chk("mid_rst_dccm_kept", dut.mem_i.dccm.dccm_d0.ram_core[3], v);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_fetch", {dut.ifu_req, dut.ifu_addr}, 33'h1_0000_0000);
    @(negedge clk);
    wait_rvalid("restart_rvalid", 40);
    chk("restart_rdata", dut.lsu_rdata, v);

    // Unmapped load returns 0; unmapped store changes nothing
    d  = $urandom() | 32'h1;
    d0 = $urandom();
    dut.mem_i.dccm.dccm_d0.ram_core[4] = d;
    dut.mem_i.dccm.dccm_d0.ram_core[0] = d0;
    prog = '{enc_lui(20'h20000, 5'd4), enc_lui(20'h10, 5'd2), addi(5'd3, 5'd0, 32'd7),
             lw(5'd3, 5'd4, 32'd0), enc_s(32'd16, 5'd3, 5'd2, 3'd2),
             addi(5'd5, 5'd0, 32'($urandom_range(1, 2047))), enc_s(32'd0, 5'd5, 5'd4, 3'd2),
             enc_jal(32'd0, 5'd0)};
    start_prog();
    rv0 = rv_cnt;
    repeat (60) @(negedge clk);
    chk("unmapped_lw_zero", dut.mem_i.dccm.dccm_d0.ram_core[4], 32'h0);
    chk("unmapped_sw_dccm", dut.mem_i.dccm.dccm_d0.ram_core[0], d0);
    chk("unmapped_sw_iccm", dut.mem_i.iccm.iccm_i0.ram_core[0], prog[0]);
    chk("unmapped_rvalid", 32'(rv_cnt - rv0), 32'd1);

    // Store to ICCM is dropped; LSU reads ICCM via its second port; program keeps running
    dut.mem_i.dccm.dccm_d0.ram_core[5] = 32'h0;
    dut.mem_i.dccm.dccm_d0.ram_core[6] = 32'h0;
    prog = '{addi(5'd1, 5'd0, 32'($urandom_range(1, 2047))), enc_s(32'd0, 5'd1, 5'd0, 3'd2),
             enc_lui(20'h10, 5'd2), lw(5'd8, 5'd0, 32'd0), enc_s(32'd24, 5'd8, 5'd2, 3'd2),
             addi(5'd7, 5'd0, 32'd0), addi(5'd7, 5'd7, 32'd1), enc_s(32'd20, 5'd7, 5'd2, 3'd2),
             enc_jal(-32'sd8, 5'd0)};
    start_prog();
    repeat (500) @(negedge clk);
    c1 = dut.mem_i.dccm.dccm_d0.ram_core[5];
    repeat (500) @(negedge clk);
    c2 = dut.mem_i.dccm.dccm_d0.ram_core[5];
    chk("iccm_store_dropped", dut.mem_i.iccm.iccm_i0.ram_core[0], prog[0]);
    chk("iccm_lsu_read", dut.mem_i.dccm.dccm_d0.ram_core[6], prog[0]);
    chk("loop_progress", 32'(c1 != 0 && c2 > c1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
